// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle RV32I main
// control FSM.
//   state_t          : FSM state encoding (also exported on state_dbg)
//   ctrl_t           : Moore control word produced by mc_ctrl_decode
//   OP_*             : RV32I major opcodes recognised in DECODE
//   ALU_* / SRC_* / WB_SRC_* : datapath mux and ALU operation selects
//   decode_opcode()  : DECODE-state opcode -> next-state mapping
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, LUI, AUIPC, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JAL, JALR, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MDR = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic state_t decode_opcode(input logic [6:0] op);
    state_t s;
    case (op)
      OP_R:              s = EXEC_R;
      OP_I:              s = EXEC_I;
      OP_LOAD, OP_STORE: s = MEM_ADDR;
      OP_BRANCH:         s = BRANCH;
      OP_JAL:            s = JAL;
      OP_JALR:           s = JALR;
      OP_LUI:            s = LUI;
      OP_AUIPC:          s = AUIPC;
      default:           s = TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: purely combinational state -> control word decode.
//   state : current FSM state
//   ctrl  : Moore control word for the datapath (all fields 0 unless listed)
// FETCH raises pc_write unconditionally here; the parent qualifies it with
// mem_ready so the PC advances exactly once per fetched instruction.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        // Speculative branch/JAL target PC+imm, latched into ALUout.
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      AUIPC: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_SRC_ALU;
      end
      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_SRC_MDR;
      end
      BRANCH: begin
        ctrl.alu_src_a     = SRC_A_RS1;
        ctrl.alu_src_b     = SRC_B_RS2;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
      end
      JAL: begin
        // Target is the PC+imm already sitting in ALUout from DECODE.
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_SRC_PC4;
        ctrl.pc_write   = 1'b1;
      end
      JALR: begin
        // ALU forms rs1+imm; the datapath clears bit 0 on the PC path.
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_SRC_PC4;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_IMM;
      end
      RST, TRAP: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath controls.
//   clk, reset_n (async, active low)
//   opcode        : IR[6:0], sampled only in DECODE
//   mem_ready     : memory completes current access this cycle
//   write_ir, pc_write, pc_write_cond, iord, mem_read, mem_write,
//   reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op : datapath controls
//   illegal_instr, bus_error : sticky trap causes, cleared only by reset
//   state_dbg     : current state encoding (state_t)
//   cycle_cnt, instret_cnt : present only with PERF_COUNTERS_EN defined
// Memory handshake: mem_read/mem_write is a request held stable in
// FETCH/MEM_RD/MEM_WR until the cycle mem_ready=1; that cycle completes the
// access and the FSM leaves the state on the next edge. A request is never
// withdrawn before completion except by reset or watchdog trap.
// MEM_TIMEOUT: cycles a request may wait without mem_ready (0 = no watchdog).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        write_ir,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal_instr,
  output logic        bus_error,
  output logic [3:0]  state_dbg
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  // Counter holds 0..MEM_TIMEOUT-1: a request reaching the last value with
  // no mem_ready traps instead of counting further.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  ctrl_t            ctrl;
  logic             is_store;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_hit;
  logic             set_ill;

  mc_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // mem_ready in the expiry cycle takes priority over the trap.
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                       (wait_cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    set_ill    = 1'b0;
    case (state)
      RST:    state_next = FETCH;
      FETCH: begin
        if (mem_ready)        state_next = DECODE;
        else if (timeout_hit) state_next = TRAP;
      end
      DECODE: begin
        state_next = decode_opcode(opcode);
        set_ill    = (state_next == TRAP);
      end
      EXEC_R, EXEC_I, LUI, AUIPC: state_next = WB_ALU;
      MEM_ADDR: state_next = is_store ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)        state_next = WB_MEM;
        else if (timeout_hit) state_next = TRAP;
      end
      MEM_WR: begin
        if (mem_ready)        state_next = FETCH;
        else if (timeout_hit) state_next = TRAP;
      end
      WB_ALU, WB_MEM, BRANCH, JAL, JALR: state_next = FETCH;
      TRAP:   state_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RST;
      is_store      <= 1'b0;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state <= state_next;
      // Load/store choice is captured in DECODE so later IR changes are ignored.
      if (state == DECODE) is_store <= (opcode == OP_STORE);
      if (state_next != state)          wait_cnt <= '0;
      else if (in_wait && !mem_ready)   wait_cnt <= wait_cnt + CNT_W'(1);
      if (set_ill)     illegal_instr <= 1'b1;
      if (timeout_hit) bus_error     <= 1'b1;
    end
  end

  assign write_ir      = (state == FETCH) && mem_ready;
  assign pc_write      = ctrl.pc_write && ((state != FETCH) || mem_ready);
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign state_dbg     = state;

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      // Retire on re-entry to FETCH; the RST->FETCH start-up edge is excluded.
      if (state_next == FETCH && state != FETCH && state != RST && state != TRAP)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
